// File: rtl/limb_serial_mul.sv
// Wide unsigned multiplier that walks all limb pairs through one registered
// WORD_LEN x WORD_LEN multiplier and sums the shifted partial products.
module limb_serial_mul #(
  parameter int unsigned WORD_LEN  = 17,
  parameter int unsigned NUM_WORDS = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [NUM_WORDS*WORD_LEN-1:0]   a,
  input  logic [NUM_WORDS*WORD_LEN-1:0]   b,
  output logic                            busy,
  output logic                            done,
  output logic [2*NUM_WORDS*WORD_LEN-1:0] p
);

  localparam int unsigned OP_W   = NUM_WORDS * WORD_LEN;
  localparam int unsigned ACC_W  = 2 * OP_W;
  localparam int unsigned PROD_W = 2 * WORD_LEN;
  localparam int unsigned IDX_W  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int unsigned S_W    = IDX_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [OP_W-1:0]     a_reg_q, a_reg_d;
  logic [OP_W-1:0]     b_reg_q, b_reg_d;
  logic [IDX_W-1:0]    i_q, i_d;
  logic [IDX_W-1:0]    j_q, j_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [PROD_W-1:0]   mul_p_q, mul_p_d;
  logic                issue_vld_q, issue_vld_d;
  logic [S_W-1:0]      issue_s_q, issue_s_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [ACC_W-1:0]    p_q, p_d;
  logic [WORD_LEN-1:0] mul_a, mul_b;

  // Limb operands presented to the single multiplier
  assign mul_a = WORD_LEN'(a_reg_q >> (32'(i_q) * WORD_LEN));
  assign mul_b = WORD_LEN'(b_reg_q >> (32'(j_q) * WORD_LEN));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      a_reg_q     <= '0;
      b_reg_q     <= '0;
      i_q         <= '0;
      j_q         <= '0;
      acc_q       <= '0;
      mul_p_q     <= '0;
      issue_vld_q <= 1'b0;
      issue_s_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      p_q         <= '0;
    end else begin
      state_q     <= state_d;
      a_reg_q     <= a_reg_d;
      b_reg_q     <= b_reg_d;
      i_q         <= i_d;
      j_q         <= j_d;
      acc_q       <= acc_d;
      mul_p_q     <= mul_p_d;
      issue_vld_q <= issue_vld_d;
      issue_s_q   <= issue_s_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      p_q         <= p_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    a_reg_d     = a_reg_q;
    b_reg_d     = b_reg_q;
    i_d         = i_q;
    j_d         = j_q;
    acc_d       = acc_q;
    p_d         = p_q;
    done_d      = 1'b0;
    issue_vld_d = 1'b0;
    issue_s_d   = S_W'(i_q) + S_W'(j_q);
    mul_p_d     = PROD_W'(mul_a) * PROD_W'(mul_b);

    // Product issued last cycle lands at limb offset i+j
    if (issue_vld_q) begin
      acc_d = acc_q + (ACC_W'(mul_p_q) << (32'(issue_s_q) * WORD_LEN));
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_reg_d = a;
          b_reg_d = b;
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        issue_vld_d = 1'b1;
        if (j_q == LAST_IDX) begin
          j_d = '0;
          if (i_q == LAST_IDX) begin
            i_d     = '0;
            state_d = S_DRAIN;
          end else begin
            i_d = i_q + IDX_W'(1);
          end
        end else begin
          j_d = j_q + IDX_W'(1);
        end
      end
      S_DRAIN: begin
        // Final partial product is folded in on this edge, so p takes acc_d
        p_d     = acc_d;
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign busy = busy_q;
  assign done = done_q;
  assign p    = p_q;

endmodule
